// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA-1 message scheduler and its W-window stages.
package sha1_pkg;

    localparam int unsigned PHASE_LEN        = 22;
    localparam int unsigned ROUNDS_PER_STAGE = 20;
    localparam int unsigned NSTAGE           = 4;
    localparam int unsigned R_LOAD           = 0;
    localparam int unsigned R_FINAL          = 21;

    typedef logic [31:0]      word_t;
    typedef word_t [15:0]     window_t;
    typedef logic [1:0]       slot_t;

endpackage

// File: rtl/sha1_msg_sched_if.sv
// Word-serial chunk input: one 32-bit word per accepted beat, slot/first tagged on word 0.
interface sha1_msg_sched_if;
    import sha1_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  in_first;
    slot_t in_slot;

    modport master (output in_valid, in_data, in_first, in_slot, input in_ready);
    modport slave  (input in_valid, in_data, in_first, in_slot, output in_ready);

endinterface

// File: rtl/sha1_w_window.sv
// 16-word W window: parallel load, or shift down one word appending the SHA-1 recurrence.
module sha1_w_window
    import sha1_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  window_t load_data,
    input  logic    shift,
    output window_t win
);

    window_t win_q;
    word_t   mix;
    word_t   next_word;

    // win_q[0] is W[t-16], win_q[15] is W[t-1].
    assign mix       = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
    assign next_word = {mix[30:0], mix[31]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
        end else if (load) begin
            win_q <= load_data;
        end else if (shift) begin
            win_q <= {next_word, win_q[15:1]};
        end
    end

    assign win = win_q;

endmodule

// File: rtl/sha1_msg_sched.sv
// Round-robin phase controller and W-stream generator for the 4-stage SHA-1 round pipeline.
module sha1_msg_sched
    import sha1_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    sha1_msg_sched_if.slave  in_if,
    output logic [3:0]       feed,
    output logic [3:0]       next,
    output slot_t            msgIn_cnt,
    output slot_t            msgOut_cnt,
    output logic             finalStage,
    output logic             first_chunk,
    output word_t            w0,
    output word_t            w1,
    output word_t            w2,
    output word_t            w3,
    output slot_t            enter_slot,
    output logic [3:0]       stage_valid
);

    typedef logic [4:0] round_t;

    slot_t             ph_q;
    round_t            r_q;
    window_t           buf_q;
    logic [3:0]        cnt_q;
    logic              full_q;
    logic              buf_first_q;
    slot_t             buf_slot_q;
    logic [NSTAGE-1:0] valid_q;
    logic              first_q;
    slot_t             out_slot_q;

    logic              boundary;
    logic              load_phase;
    logic              round_phase;
    logic              load_chunk;
    logic              accept;
    logic [NSTAGE-1:0] win_load;
    window_t           win_in [NSTAGE];
    window_t           win    [NSTAGE];

    assign boundary    = (r_q == round_t'(R_FINAL));
    assign load_phase  = (r_q == round_t'(R_LOAD));
    assign round_phase = !boundary && !load_phase;
    assign enter_slot  = ph_q + 2'd1;
    assign load_chunk  = boundary && full_q && (buf_slot_q == enter_slot);
    assign accept      = in_if.in_valid && !full_q;
    assign in_if.in_ready = !full_q;

    // Stage 0 takes the buffer only when its slot is due; otherwise it keeps a bubble window.
    assign win_load  = {{(NSTAGE-1){boundary}}, load_chunk};
    assign win_in[0] = buf_q;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k > 0) begin : g_chain
            assign win_in[k] = win[k-1];
        end
        sha1_w_window u_win (
            .clk       (clk),
            .reset     (reset),
            .load      (win_load[k]),
            .load_data (win_in[k]),
            .shift     (round_phase),
            .win       (win[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q        <= '0;
            r_q         <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            buf_first_q <= 1'b0;
            buf_slot_q  <= '0;
            valid_q     <= '0;
            first_q     <= 1'b0;
            out_slot_q  <= '0;
        end else begin
            if (boundary) begin
                r_q     <= '0;
                ph_q    <= ph_q + 2'd1;
                valid_q <= {valid_q[NSTAGE-2:0], load_chunk};
                first_q <= load_chunk && buf_first_q;
            end else begin
                r_q <= r_q + 5'd1;
            end
            // Lags the phase by one cycle so the final add at r=0 still sees the outgoing slot.
            if (load_phase) begin
                out_slot_q <= ph_q - 2'd3;
            end
            if (load_chunk) begin
                full_q <= 1'b0;
                cnt_q  <= '0;
            end else if (accept) begin
                buf_q[cnt_q] <= in_if.in_data;
                if (cnt_q == 4'd0) begin
                    buf_first_q <= in_if.in_first;
                    buf_slot_q  <= in_if.in_slot;
                end
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    full_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        feed        = load_phase  ? valid_q : '0;
        next        = round_phase ? valid_q : '0;
        finalStage  = boundary && valid_q[NSTAGE-1];
        first_chunk = load_phase && valid_q[0] && first_q;
        w0          = round_phase ? win[0][0] : '0;
        w1          = round_phase ? win[1][0] : '0;
        w2          = round_phase ? win[2][0] : '0;
        w3          = round_phase ? win[3][0] : '0;
    end

    assign msgIn_cnt   = ph_q;
    assign msgOut_cnt  = out_slot_q;
    assign stage_valid = valid_q;

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Randomized bench for sha1_msg_sched against a phase/slot-level model with full W expansion.
module tb_sha1_msg_sched;
    import sha1_pkg::*;

    typedef struct packed {
        logic [79:0][31:0] w;
        logic              first;
        logic [1:0]        slot;
    } chunk_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha1_msg_sched_if bus ();

    logic [3:0]        feed;
    logic [3:0]        next;
    logic [3:0]        stage_valid;
    logic [1:0]        msgIn_cnt;
    logic [1:0]        msgOut_cnt;
    logic [1:0]        enter_slot;
    logic              finalStage;
    logic              first_chunk;
    logic [3:0][31:0]  wv;

    sha1_msg_sched dut (
        .clk         (clk),
        .reset       (reset),
        .in_if       (bus),
        .feed        (feed),
        .next        (next),
        .msgIn_cnt   (msgIn_cnt),
        .msgOut_cnt  (msgOut_cnt),
        .finalStage  (finalStage),
        .first_chunk (first_chunk),
        .w0          (wv[0]),
        .w1          (wv[1]),
        .w2          (wv[2]),
        .w3          (wv[3]),
        .enter_slot  (enter_slot),
        .stage_valid (stage_valid)
    );

    int     checks = 0;
    int     failures = 0;
    int     n;            // cycles since reset release
    int     ent[int];     // absolute phase number -> chunk index entering stage0
    chunk_t chunks[$];
    chunk_t send_q[$];
    int     send_idx;
    bit     gaps;
    word_t  bw[$];
    logic   bfirst;
    logic [1:0] bslot;

    function automatic chunk_t expand(input logic [15:0][31:0] m, input logic f,
                                      input logic [1:0] s);
        chunk_t c;
        word_t  x;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) begin
                c.w[t] = m[t];
            end else begin
                x = c.w[t-3] ^ c.w[t-8] ^ c.w[t-14] ^ c.w[t-16];
                c.w[t] = (x << 1) | (x >> 31);
            end
        end
        c.first = f;
        c.slot  = s;
        return c;
    endfunction

    function automatic int stg(input int k);
        int p;
        p = n / 22 - k;
        if (p >= 0 && ent.exists(p)) return ent[p];
        return -1;
    endfunction

    function automatic chunk_t rand_chunk(input logic f, input logic [1:0] s);
        logic [15:0][31:0] m;
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        return expand(m, f, s);
    endfunction

    // Drive one cycle of input and advance the model over the coming edge.
    task automatic tick();
        int p;
        int r;
        logic acc;
        logic [15:0][31:0] m;
        p = n / 22;
        r = n % 22;
        if (send_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = send_q[0].w[send_idx];
            if (send_idx == 0) begin
                bus.in_first = send_q[0].first;
                bus.in_slot  = send_q[0].slot;
            end else begin
                bus.in_first = 1'($urandom);
                bus.in_slot  = 2'($urandom);
            end
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            bus.in_first = 1'($urandom);
            bus.in_slot  = 2'($urandom);
        end
        acc = bus.in_valid && (bw.size() < 16);
        if (r == 21 && bw.size() == 16 && int'(bslot) == (p + 1) % 4) begin
            for (int i = 0; i < 16; i++) m[i] = bw[i];
            chunks.push_back(expand(m, bfirst, bslot));
            ent[p+1] = chunks.size() - 1;
            bw.delete();
        end else if (acc) begin
            if (bw.size() == 0) begin
                bfirst = bus.in_first;
                bslot  = bus.in_slot;
            end
            bw.push_back(bus.in_data);
            send_idx++;
            if (send_idx == 16) begin
                void'(send_q.pop_front());
                send_idx = 0;
            end
        end
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        ent.delete();
        bw.delete();
        send_q.delete();
        send_idx = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({feed, next, msgIn_cnt, msgOut_cnt, finalStage, first_chunk, wv, stage_valid} !== '0) begin
            failures++;
            $display("FAIL reset_zero: got feed=%b next=%b in=%0d out=%0d fin=%b fc=%b sv=%b expected all 0",
                     feed, next, msgIn_cnt, msgOut_cnt, finalStage, first_chunk, stage_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || enter_slot !== 2'd1) begin
            failures++;
            $display("FAIL reset_ready: got in_ready=%b enter_slot=%0d expected 1/1",
                     bus.in_ready, enter_slot);
        end
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 200; c++) begin
            checks++;
            if ({feed, next, finalStage, stage_valid} !== '0) begin
                failures++;
                $display("FAIL idle_quiet n=%0d: got feed=%b next=%b fin=%b sv=%b expected 0",
                         n, feed, next, finalStage, stage_valid);
            end
            checks++;
            if (msgIn_cnt !== 2'((n / 22) % 4) || enter_slot !== 2'((n / 22 + 1) % 4)) begin
                failures++;
                $display("FAIL idle_phase n=%0d: got ph=%0d enter=%0d expected %0d/%0d",
                         n, msgIn_cnt, enter_slot, (n / 22) % 4, (n / 22 + 1) % 4);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_ready n=%0d: got %b expected 1", n, bus.in_ready);
            end
            tick();
        end
    endtask

    task automatic test_abc();
        logic [15:0][31:0] m;
        int id;
        int b;
        int c;
        m = '0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        id = chunks.size();
        gaps = 1'b1;
        send_q.push_back(expand(m, 1'b1, 2'd1));
        c = 0;
        while (!(n % 22 == 0 && stg(0) == id) && c < 200) begin
            tick();
            c++;
        end
        checks++;
        if (c >= 200) begin
            failures++;
            $display("FAIL abc_entry: got no entry within 200 cycles expected entry");
        end else begin
            b = n;
            checks++;
            if (feed[0] !== 1'b1 || first_chunk !== 1'b1) begin
                failures++;
                $display("FAIL abc_feed: got feed=%b first_chunk=%b expected feed[0]=1 first=1",
                         feed, first_chunk);
            end
            tick();
            checks++;
            if (wv[0] !== 32'h61626380) begin
                failures++;
                $display("FAIL abc_w0_r1: got %h expected 61626380", wv[0]);
            end
            repeat (15) tick();
            checks++;
            if (wv[0] !== 32'h00000018) begin
                failures++;
                $display("FAIL abc_w0_r16: got %h expected 00000018", wv[0]);
            end
            tick();
            checks++;
            if (wv[0] !== 32'hC2C4C700) begin
                failures++;
                $display("FAIL abc_w16: got %h expected c2c4c700", wv[0]);
            end
            repeat (6) tick();
            checks++;
            if (wv[1] !== chunks[id].w[20] || next[1] !== 1'b1) begin
                failures++;
                $display("FAIL abc_w20: got w1=%h next=%b expected %h next[1]=1",
                         wv[1], next, chunks[id].w[20]);
            end
            while (n < b + 87) tick();
            checks++;
            if (finalStage !== 1'b1 || msgOut_cnt !== 2'd1) begin
                failures++;
                $display("FAIL abc_final: got fin=%b out=%0d expected fin=1 out=1",
                         finalStage, msgOut_cnt);
            end
            tick();
            checks++;
            if (finalStage !== 1'b0 || msgOut_cnt !== 2'd1) begin
                failures++;
                $display("FAIL abc_out_hold: got fin=%b out=%0d expected fin=0 out=1",
                         finalStage, msgOut_cnt);
            end
        end
    endtask

    task automatic test_slot_mismatch();
        int c;
        c = 0;
        while (!(n % 22 == 0 && (n / 22) % 4 == 0) && c < 100) begin
            tick();
            c++;
        end
        gaps = 1'b0;
        send_q.push_back(rand_chunk(1'b1, 2'd3));
        send_q.push_back(rand_chunk(1'b0, 2'd0));
        for (int b = 1; b <= 3; b++) begin
            do tick(); while (n % 22 != 0);
            checks++;
            if (b < 3) begin
                if (stage_valid[0] !== 1'b0 || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL mismatch_bubble%0d: got sv0=%b ready=%b expected 0/0",
                             b, stage_valid[0], bus.in_ready);
                end
            end else begin
                if (stage_valid[0] !== 1'b1 || feed[0] !== 1'b1 || msgIn_cnt !== 2'd3) begin
                    failures++;
                    $display("FAIL mismatch_enter: got sv0=%b feed0=%b ph=%0d expected 1/1/3",
                             stage_valid[0], feed[0], msgIn_cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e[$];
        logic ef[$];
        logic [3:0] ev;
        logic efc;
        int r;
        gaps = 1'b1;
        send_q.push_back(rand_chunk(1'b1, 2'd2));
        send_q.push_back(rand_chunk(1'b0, 2'd2));
        for (int c = 0; c < 400; c++) begin
            r = n % 22;
            for (int k = 0; k < 4; k++) ev[k] = (stg(k) >= 0);
            efc = (r == 0 && ev[0]) ? chunks[stg(0)].first : 1'b0;
            checks++;
            if (stage_valid !== ev || feed !== ((r == 0) ? ev : 4'b0)
                || next !== ((r >= 1 && r <= 20) ? ev : 4'b0)) begin
                failures++;
                $display("FAIL b2b_ctrl n=%0d: got sv=%b feed=%b next=%b expected sv=%b r=%0d",
                         n, stage_valid, feed, next, ev, r);
            end
            checks++;
            if (finalStage !== (r == 21 && ev[3]) || first_chunk !== efc) begin
                failures++;
                $display("FAIL b2b_flags n=%0d: got fin=%b fc=%b expected fin=%b fc=%b",
                         n, finalStage, first_chunk, (r == 21 && ev[3]), efc);
            end
            checks++;
            if (msgOut_cnt !== ((r == 0) ? 2'((n / 22) % 4) : 2'((n / 22 + 1) % 4))) begin
                failures++;
                $display("FAIL b2b_out n=%0d: got %0d expected %0d", n, msgOut_cnt,
                         (r == 0) ? (n / 22) % 4 : (n / 22 + 1) % 4);
            end
            for (int k = 0; k < 4; k++) begin
                if (ev[k] && r >= 1 && r <= 20) begin
                    checks++;
                    if (wv[k] !== chunks[stg(k)].w[20*k + r - 1]) begin
                        failures++;
                        $display("FAIL b2b_w%0d n=%0d: got %h expected %h", k, n, wv[k],
                                 chunks[stg(k)].w[20*k + r - 1]);
                    end
                end
            end
            if (feed[0] === 1'b1 && msgIn_cnt === 2'd2) begin
                e.push_back(n);
                ef.push_back(first_chunk);
            end
            tick();
        end
        checks++;
        if (e.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d slot-2 entries expected 2", e.size());
        end else if (e[1] - e[0] != 88 || ef[0] !== 1'b1 || ef[1] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_spacing: got gap=%0d first=%b/%b expected 88 first=1/0",
                     e[1] - e[0], ef[0], ef[1]);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        c = 0;
        while (!(n % 22 == 2 && (n / 22) % 4 != 0 && bw.size() == 0 && send_q.size() == 0)
               && c < 200) begin
            tick();
            c++;
        end
        gaps = 1'b0;
        send_q.push_back(rand_chunk(1'b1, 2'd0));
        repeat (8) tick();
        send_q.delete();
        send_idx = 0;
        bus.in_valid = 1'b0;
        checks++;
        if (bw.size() != 8 || bus.in_ready !== 1'b1 || msgIn_cnt === 2'd0) begin
            failures++;
            $display("FAIL midreset_setup: got buffered=%0d ready=%b ph=%0d expected 8/1/nonzero",
                     bw.size(), bus.in_ready, msgIn_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({feed, next, msgIn_cnt, msgOut_cnt, finalStage, first_chunk, wv, stage_valid} !== '0
            || bus.in_ready !== 1'b1 || enter_slot !== 2'd1) begin
            failures++;
            $display("FAIL midreset_clear: got sv=%b ph=%0d out=%0d ready=%b enter=%0d expected reset values",
                     stage_valid, msgIn_cnt, msgOut_cnt, bus.in_ready, enter_slot);
        end
        release_reset();
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1 || stage_valid !== 4'b0 || feed !== 4'b0) begin
                failures++;
                $display("FAIL midreset_empty n=%0d: got ready=%b sv=%b feed=%b expected 1/0/0",
                         n, bus.in_ready, stage_valid, feed);
            end
            tick();
        end
        // A fresh chunk must start at word 0, proving the partial buffer was dropped.
        send_q.push_back(rand_chunk(1'b1, 2'd1));
        for (int i = 0; i < 150; i++) begin
            if (stg(0) >= 0 && n % 22 >= 1 && n % 22 <= 20) begin
                checks++;
                if (wv[0] !== chunks[stg(0)].w[n % 22 - 1]) begin
                    failures++;
                    $display("FAIL midreset_data n=%0d: got %h expected %h", n, wv[0],
                             chunks[stg(0)].w[n % 22 - 1]);
                end
            end
            tick();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_first = 1'b0;
        bus.in_slot  = '0;
        gaps     = 1'b0;
        n        = 0;
        send_idx = 0;
        test_reset();
        test_idle();
        test_abc();
        test_slot_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha1_msg_sched.md
Name: sha1_msg_sched

Overview:
- Upstream controller and message scheduler for the 4-stage SHA-1 round pipeline (stages op0..op3, 20 rounds each).
- Accepts 512-bit chunks as 16 word-serial writes tagged with a slot id (0..3).
- Runs the fixed 4-slot round-robin phase sequence and drives every control input of the pipeline: feed, next, msgIn_cnt, msgOut_cnt, finalStage, first_chunk.
- Generates the expanded W[t] stream for each stage from a per-stage 16-word window that travels down the pipeline with its message.

Parameters:
- PHASE_LEN, 22, cycles per phase: r=0 load, r=1..20 rounds, r=21 finalize. Fixed; other values unsupported.
- NSTAGE, 4, pipeline stages and slots. Fixed.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  input word valid
- in_ready  out  1  buffer can accept a word
- in_data  in  32  message word, big-endian, W0 first
- in_first  in  1  chunk is first of its message; sampled with word 0
- in_slot  in  2  slot id of the chunk; sampled with word 0
- feed  out  4  per-stage load strobe
- next  out  4  per-stage round-advance
- msgIn_cnt  out  2  slot entering stage0
- msgOut_cnt  out  2  slot leaving stage3
- finalStage  out  1  stage3 finished a valid chunk
- first_chunk  out  1  stage0 chunk is a first chunk
- w0..w3  out  32 each  W word for stage k
- enter_slot  out  2  slot that enters stage0 at the next phase boundary
- stage_valid  out  4  stage k holds a real chunk

Behaviour:
- Reset is asynchronous, active-high. Clock is clk.
- On reset: all outputs 0, except in_ready=1 and enter_slot=1. Phase counter 0, r=0, all windows 0, buffer empty.
- Phase counter ph (2 bits) and round counter r (0..21) free-run from reset. r wraps 21->0, and ph increments on that wrap.
- Slot mapping:
  - msgIn_cnt = ph.
  - enter_slot = ph+1.
  - Slot in stage k = ph-k (mod 4).
  - msgOut_cnt = ph-3. It updates at r=1, not r=0, so the pipeline's final hash add in r=0 still sees the outgoing slot.
- Input buffer:
  - 16x32 with a 4-bit word count. in_ready = !full. A word is accepted when in_valid & in_ready.
  - Word 0 latches in_first and in_slot.
  - full is set after word 15.
- Boundary edge (the edge leaving r=21):
  - Windows shift: window[k] <= window[k-1] and stage_valid[k] <= stage_valid[k-1] for k=1..3.
  - window[0] <= buffer and stage_valid[0] <= 1 if full and buf_slot==enter_slot. The buffer empties and the first flag is carried with the chunk.
  - Otherwise stage_valid[0] <= 0 (bubble) and the buffer is held.
- r=0:
  - feed[k] = stage_valid[k]; next=0.
  - first_chunk = stage_valid[0] & carried first flag.
  - w0..w3 = 0.
- r=1..20:
  - next[k] = stage_valid[k]; feed=0.
  - wk = window[k][0], which equals W[20k + r-1] of that stage's message.
  - Each cycle every window shifts down one word and appends rotl1(win[13]^win[8]^win[2]^win[0]).
  - Bubble windows shift too; their outputs are don't-care but must be deterministic (0 after reset).
- r=21: finalStage = stage_valid[3]; next=0, feed=0.
- Latency: the chunk loaded at boundary B gets finalStage at cycle B + 3*22 + 21 = B+87.
- Same-slot chaining: the next chunk of a slot can enter only at its next own boundary (B+88). A chunk whose slot does not match waits in the buffer, and no new words are accepted while it waits.
- A word accepted on the boundary edge is impossible (buffer is full at that point). The buffer refills starting the cycle after.
- Reset mid-chunk or mid-phase: everything clears per the reset values, and the partial buffer is discarded.

Decomposition:
- Shared package sha1_pkg:
  - constants PHASE_LEN=22, ROUNDS_PER_STAGE=20, NSTAGE=4, R_LOAD=0, R_FINAL=21
  - typedefs word_t (32b), window_t (16 x word_t), slot_t (2b)
- One sub-module, sha1_w_window: a 16-word shift register with load, shift and recurrence output. Instantiate it four times.

Test Plan:
- Reset, idle for 200 cycles -> feed, next and finalStage stay 0; ph cycles 0..3 every 22 cycles; in_ready=1.
- Load the "abc" chunk, slot 1, first=1, before the ph=0->1 boundary -> r=0 feed[0]=1, first_chunk=1. At r=1 w0=0x61626380. At r=16 w0=0x00000018. At r=17 w0=0xC2C4C700 (W16).
- Same chunk -> 22 cycles later stage1 r=1 gives w1=W20. finalStage=1 at B+87 with msgOut_cnt=1 through the following r=0. Integrated with the pipeline, hash = a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
- Chunk tagged slot 3 loaded while enter_slot=1 -> two bubble boundaries (stage_valid[0]=0, in_ready=0), then it enters at ph=3.
- Two chunks of slot 2 back-to-back -> the second enters exactly 88 cycles after the first, with first_chunk=0.
- Assert reset at r=10 with 8 words buffered -> all outputs 0 immediately; after release the buffer is empty and in_ready=1.
